// File: rtl/sata_tx_cont_gen_pkg.sv
// SATA primitive encodings and helpers shared by the CONT generator.
// Holds the repeatable-primitive classification used to decide CONT eligibility.
package sata_tx_cont_gen_pkg;

  localparam logic [31:0] PRIM_ALIGN   = 32'h7B4A_4ABC;
  localparam logic [31:0] PRIM_CONT    = 32'h9999_AA7C;
  localparam logic [31:0] PRIM_DMAT    = 32'h3636_B57C;
  localparam logic [31:0] PRIM_EOF     = 32'hD5D5_B57C;
  localparam logic [31:0] PRIM_HOLD    = 32'hD5D5_AA7C;
  localparam logic [31:0] PRIM_HOLDA   = 32'h9595_AA7C;
  localparam logic [31:0] PRIM_PMACK   = 32'h9595_957C;
  localparam logic [31:0] PRIM_PMNAK   = 32'hF5F5_957C;
  localparam logic [31:0] PRIM_PMREQ_P = 32'h1717_B57C;
  localparam logic [31:0] PRIM_PMREQ_S = 32'h7575_957C;
  localparam logic [31:0] PRIM_R_ERR   = 32'h5656_B57C;
  localparam logic [31:0] PRIM_R_IP    = 32'h5555_B57C;
  localparam logic [31:0] PRIM_R_OK    = 32'h3535_B57C;
  localparam logic [31:0] PRIM_R_RDY   = 32'h4A4A_957C;
  localparam logic [31:0] PRIM_SOF     = 32'h3737_B57C;
  localparam logic [31:0] PRIM_SYNC    = 32'hB5B5_957C;
  localparam logic [31:0] PRIM_WTRM    = 32'h5858_B57C;
  localparam logic [31:0] PRIM_X_RDY   = 32'h5757_B57C;

  localparam logic [15:0] SCR_SEED = 16'hFFFF;

  function automatic logic prim_repeatable(input logic [31:0] dw, input logic isk);
    logic rep;
    rep = 1'b0;
    if (isk) begin
      case (dw)
        PRIM_SYNC, PRIM_X_RDY, PRIM_R_RDY, PRIM_R_IP, PRIM_R_OK, PRIM_R_ERR,
        PRIM_HOLD, PRIM_HOLDA, PRIM_WTRM, PRIM_PMREQ_P, PRIM_PMREQ_S,
        PRIM_PMACK, PRIM_PMNAK: rep = 1'b1;
        default:                rep = 1'b0;
      endcase
    end
    return rep;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sata_tx_cont_gen_scrambler.sv
// SATA LFSR scrambler (x^16+x^15+x^13+x^4+1, seed 0xFFFF), one dword per enabled cycle.
// dout reflects the current state combinationally; the state advances 32 bits when en is high.
module sata_tx_cont_gen_scrambler
  import sata_tx_cont_gen_pkg::*;
#(
  parameter bit PRIM_SCRAMBLER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] key;

  always_comb begin
    logic [15:0] s;
    s   = lfsr_q;
    key = '0;
    for (int i = 0; i < 32; i++) begin
      key[i] = s[15];
      s      = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    end
    lfsr_d = s;
  end

  // Primitive-junk mode emits the raw keystream; data mode whitens din.
  assign dout = PRIM_SCRAMBLER ? key : (key ^ din);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SCR_SEED;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sata_tx_cont_gen.sv
// Transmit CONT generator: replaces long repeatable-primitive runs with CONT + scrambled junk.
// Feature macro SATA_CONT_GEN_EN; when undefined the block is a 1-cycle registered, stallable copy.
module sata_tx_cont_gen
  import sata_tx_cont_gen_pkg::*;
#(
  parameter int MIN_REPEAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_ready,
  input  logic [31:0] in_dout,
  input  logic        in_isk,
  output logic [31:0] out_dout,
  output logic        out_isk,
  output logic        cont_active,
  output logic [15:0] suppressed_count
);

  // Legal range is 2..15; an out-of-range value shows up as this scope in the hierarchy.
  if (MIN_REPEAT < 2 || MIN_REPEAT > 15) begin : g_min_repeat_out_of_range
  end

`ifdef SATA_CONT_GEN_EN
  localparam logic [3:0] MIN_REP4 = 4'(MIN_REPEAT);

  typedef enum logic [1:0] {ST_PASS, ST_REPEAT, ST_JUNK} state_e;

  state_e      state_q, state_d;
  logic [31:0] last_prim_q, last_prim_d;
  logic [3:0]  rep_cnt_q, rep_cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        isk_q, isk_d;
  logic        cont_q, cont_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_rep, in_match, scr_en;
  logic [31:0] scr_dout;

  assign in_rep   = prim_repeatable(in_dout, in_isk);
  assign in_match = in_isk && (in_dout == last_prim_q);
  assign scr_en   = phy_ready && (state_q == ST_JUNK) && in_match;

  sata_tx_cont_gen_scrambler #(
    .PRIM_SCRAMBLER(1'b1)
  ) u_scrambler (
    .clk (clk),
    .rst (rst),
    .en  (scr_en),
    .din (32'd0),
    .dout(scr_dout)
  );

  always_comb begin
    state_d     = state_q;
    last_prim_d = last_prim_q;
    rep_cnt_d   = rep_cnt_q;
    dout_d      = dout_q;
    isk_d       = isk_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    if (phy_ready) begin
      dout_d = in_dout;
      isk_d  = in_isk;
      cont_d = 1'b0;
      case (state_q)
        ST_PASS: begin
          if (in_rep) begin
            last_prim_d = in_dout;
            rep_cnt_d   = 4'd1;
            state_d     = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          if (in_match && (rep_cnt_q < MIN_REP4)) begin
            rep_cnt_d = rep_cnt_q + 4'd1;
          end else if (in_match) begin
            dout_d  = PRIM_CONT;
            isk_d   = 1'b1;
            state_d = ST_JUNK;
          end else if (in_rep) begin
            last_prim_d = in_dout;
            rep_cnt_d   = 4'd1;
          end else begin
            state_d = ST_PASS;
          end
        end
        ST_JUNK: begin
          if (in_match) begin
            dout_d = scr_dout;
            isk_d  = 1'b0;
            cont_d = 1'b1;
            cnt_d  = sat_inc16(cnt_q);
          end else if (in_rep) begin
            // Run broken by a new repeatable primitive: it becomes run length 1.
            last_prim_d = in_dout;
            rep_cnt_d   = 4'd1;
            state_d     = ST_REPEAT;
          end else begin
            state_d = ST_PASS;
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PASS;
      rep_cnt_q <= 4'd0;
      dout_q    <= PRIM_SYNC;
      isk_q     <= 1'b1;
      cont_q    <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      dout_q    <= dout_d;
      isk_q     <= isk_d;
      cont_q    <= cont_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    last_prim_q <= last_prim_d;
  end

  assign out_dout         = dout_q;
  assign out_isk          = isk_q;
  assign cont_active      = cont_q;
  assign suppressed_count = cnt_q;

`else
  logic [31:0] dout_q;
  logic        isk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= PRIM_SYNC;
      isk_q  <= 1'b1;
    end else if (phy_ready) begin
      dout_q <= in_dout;
      isk_q  <= in_isk;
    end
  end

  assign out_dout         = dout_q;
  assign out_isk          = isk_q;
  assign cont_active      = 1'b0;
  assign suppressed_count = 16'd0;
`endif

endmodule

// File: tb/tb_sata_tx_cont_gen.sv
// Self-checking bench for sata_tx_cont_gen; reference model tracks run lengths of accepted
// dwords and derives junk from the scrambler's bit-sequence recurrence.
module tb_sata_tx_cont_gen;

`ifdef SATA_CONT_GEN_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int MINR = 2;

  localparam logic [31:0] SYNC  = 32'hB5B5_957C;
  localparam logic [31:0] CONT  = 32'h9999_AA7C;
  localparam logic [31:0] X_RDY = 32'h5757_B57C;
  localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
  localparam logic [31:0] R_IP  = 32'h5555_B57C;
  localparam logic [31:0] SOF   = 32'h3737_B57C;
  localparam logic [31:0] EOF   = 32'hD5D5_B57C;
  localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
  localparam logic [31:0] R_OK  = 32'h3535_B57C;

  localparam int GBITS = 32 * 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phy_ready = 1'b0;
  logic [31:0] in_dout = 32'd0;
  logic        in_isk = 1'b0;
  logic [31:0] out_dout;
  logic        out_isk;
  logic        cont_active;
  logic [15:0] suppressed_count;

  sata_tx_cont_gen #(.MIN_REPEAT(MINR)) dut (
    .clk             (clk),
    .rst             (rst),
    .phy_ready       (phy_ready),
    .in_dout         (in_dout),
    .in_isk          (in_isk),
    .out_dout        (out_dout),
    .out_isk         (out_isk),
    .cont_active     (cont_active),
    .suppressed_count(suppressed_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Keystream bits: g[t] is the t-th emitted bit after seeding with all ones.
  bit g [0:GBITS-1];

  logic [31:0] exp_dout = SYNC;
  logic        exp_isk  = 1'b1;
  logic        exp_cont = 1'b0;
  logic [15:0] exp_cnt  = 16'd0;
  int          run_len  = 0;
  logic [31:0] run_prim = 32'd0;
  int          jidx     = 0;

  function automatic bit tb_repeatable(input logic [31:0] d, input logic k);
    logic [31:0] lst [13];
    lst = '{32'hB5B5957C, 32'h5757B57C, 32'h4A4A957C, 32'h5555B57C, 32'h3535B57C,
            32'h5656B57C, 32'hD5D5AA7C, 32'h9595AA7C, 32'h5858B57C, 32'h1717B57C,
            32'h7575957C, 32'h9595957C, 32'hF5F5957C};
    if (!k) return 1'b0;
    foreach (lst[i]) if (lst[i] == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] junk_word(input int k);
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = g[(32 * k + i) % GBITS];
    return w;
  endfunction

  task automatic drive(input logic [31:0] d, input logic k, input logic rdy, input logic r);
    @(negedge clk);
    in_dout   = d;
    in_isk    = k;
    phy_ready = rdy;
    rst       = r;
    @(posedge clk);
    if (r) begin
      exp_dout = SYNC; exp_isk = 1'b1; exp_cont = 1'b0; exp_cnt = 16'd0;
      run_len = 0; jidx = 0;
    end else if (rdy) begin
      exp_dout = d; exp_isk = k; exp_cont = 1'b0;
      if (EN && tb_repeatable(d, k)) begin
        if (run_len > 0 && d == run_prim) run_len++;
        else begin run_len = 1; run_prim = d; end
        if (run_len == MINR + 1) begin
          exp_dout = CONT; exp_isk = 1'b1;
        end else if (run_len > MINR + 1) begin
          exp_dout = junk_word(jidx); exp_isk = 1'b0; exp_cont = 1'b1;
          jidx++;
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end else begin
        run_len = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'($urandom), 1'($urandom), 1'b1);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {SYNC, 1'b1, 1'b0, 16'd0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=1 cont=0 cnt=0",
                 i, out_dout, out_isk, cont_active, suppressed_count, SYNC);
      end
    end
  endtask

  task automatic test_sync_run();
    drive(SYNC, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(SYNC, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
        n_fail++;
        $display("FAIL sync_run[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=%b cont=%b cnt=%0d",
                 i, out_dout, out_isk, cont_active, suppressed_count, exp_dout, exp_isk, exp_cont, exp_cnt);
      end
      if (i == 2) begin
        n_tests++;
        if (out_dout !== (EN ? CONT : SYNC)) begin
          n_fail++;
          $display("FAIL sync_run_cont: got %h, want %h", out_dout, EN ? CONT : SYNC);
        end
      end
    end
    n_tests++;
    if (suppressed_count !== (EN ? 16'd7 : 16'd0)) begin
      n_fail++;
      $display("FAIL sync_run_count: got %0d, want %0d", suppressed_count, EN ? 7 : 0);
    end
  endtask

  task automatic test_sync_to_xrdy();
    logic [31:0] seq [9];
    seq = '{SYNC, SYNC, SYNC, SYNC, SYNC, X_RDY, X_RDY, X_RDY, X_RDY};
    drive(SYNC, 1'b1, 1'b1, 1'b1);
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b1, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
        n_fail++;
        $display("FAIL sync_to_xrdy[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=%b cont=%b cnt=%0d",
                 i, out_dout, out_isk, cont_active, suppressed_count, exp_dout, exp_isk, exp_cont, exp_cnt);
      end
      if (i == 5) begin
        n_tests++;
        if ({out_dout, out_isk, cont_active} !== {X_RDY, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL xrdy_first: got dout=%h isk=%b cont=%b, want dout=%h isk=1 cont=0",
                   out_dout, out_isk, cont_active, X_RDY);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] fr_dout;
    logic        fr_isk, fr_cont;
    logic [15:0] fr_cnt;
    drive(SYNC, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(HOLD, 1'b1, 1'b1, 1'b0);
    fr_dout = out_dout; fr_isk = out_isk; fr_cont = cont_active; fr_cnt = suppressed_count;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'($urandom), 1'b0, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
        n_fail++;
        $display("FAIL stall_frozen[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=%b cont=%b cnt=%0d",
                 i, out_dout, out_isk, cont_active, suppressed_count, exp_dout, exp_isk, exp_cont, exp_cnt);
      end
    end
    n_tests++;
    if ({fr_dout, fr_isk, fr_cont, fr_cnt} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
      n_fail++;
      $display("FAIL stall_hold: got dout=%h cnt=%0d before stall, want dout=%h cnt=%0d after",
               fr_dout, fr_cnt, exp_dout, exp_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive(HOLD, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
        n_fail++;
        $display("FAIL stall_resume[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=%b cont=%b cnt=%0d",
                 i, out_dout, out_isk, cont_active, suppressed_count, exp_dout, exp_isk, exp_cont, exp_cnt);
      end
    end
    n_tests++;
    if (suppressed_count !== (EN ? 16'd3 : 16'd0)) begin
      n_fail++;
      $display("FAIL stall_count: got %0d, want %0d", suppressed_count, EN ? 3 : 0);
    end
  endtask

  task automatic test_frame();
    logic [31:0] d [6];
    logic        k [6];
    d = '{SOF, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, EOF};
    k = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    foreach (d[i]) begin
      drive(d[i], k[i], 1'b1, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active} !== {d[i], k[i], 1'b0}) begin
        n_fail++;
        $display("FAIL frame[%0d]: got dout=%h isk=%b cont=%b, want dout=%h isk=%b cont=0",
                 i, out_dout, out_isk, cont_active, d[i], k[i]);
      end
    end
  endtask

  task automatic test_align();
    for (int i = 0; i < 5; i++) begin
      drive(ALIGN, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active} !== {ALIGN, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL align[%0d]: got dout=%h isk=%b cont=%b, want dout=%h isk=1 cont=0",
                 i, out_dout, out_isk, cont_active, ALIGN);
      end
    end
  endtask

  task automatic test_reset_mid_junk();
    for (int i = 0; i < 6; i++) drive(SYNC, 1'b1, 1'b1, 1'b0);
    drive(SYNC, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({out_dout, out_isk, cont_active, suppressed_count} !== {SYNC, 1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL mid_reset: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=1 cont=0 cnt=0",
               out_dout, out_isk, cont_active, suppressed_count, SYNC);
    end
    for (int i = 0; i < 6; i++) begin
      drive(SYNC, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=%b cont=%b cnt=%0d",
                 i, out_dout, out_isk, cont_active, suppressed_count, exp_dout, exp_isk, exp_cont, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] alpha [7];
    logic [31:0] d;
    logic        k;
    alpha = '{SYNC, HOLD, R_IP, X_RDY, R_OK, SOF, ALIGN};
    d = SYNC; k = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 25) begin
        if ($urandom_range(9) < 2) begin d = $urandom; k = 1'b0; end
        else begin d = alpha[$urandom_range(6)]; k = 1'b1; end
      end
      drive(d, k, $urandom_range(99) < 85, $urandom_range(999) < 5);
      n_tests++;
      if ({out_dout, out_isk, cont_active, suppressed_count} !== {exp_dout, exp_isk, exp_cont, exp_cnt}) begin
        n_fail++;
        $display("FAIL random[%0d]: got dout=%h isk=%b cont=%b cnt=%0d, want dout=%h isk=%b cont=%b cnt=%0d",
                 i, out_dout, out_isk, cont_active, suppressed_count, exp_dout, exp_isk, exp_cont, exp_cnt);
      end
    end
  endtask

  initial begin
    for (int t = 0; t < GBITS; t++) begin
      if (t < 16) g[t] = 1'b1;
      else g[t] = g[t-16] ^ g[t-15] ^ g[t-13] ^ g[t-4];
    end
    test_reset();
    test_sync_run();
    test_sync_to_xrdy();
    test_stall();
    test_frame();
    test_align();
    test_reset_mid_junk();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
